// File: rtl/slave_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slave_port_pkg
//  Description : Shared serial-bus definitions used by both ends of the link
//                (slave_port and master_port): default bus widths, the port
//                state encoding and small elaboration-time helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package slave_port_pkg;

  // Default slave-local address width and data word width.
  localparam int BUS_ADDR_WIDTH = 12;
  localparam int BUS_DATA_WIDTH = 8;

  // Port state encoding, shared so both ends of the link decode alike.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_RREQ  = 3'd4,
    ST_RWAIT = 3'd5,
    ST_SEND  = 3'd6
  } bus_state_e;

  // Larger of two widths; sizes the shared bit counter.
  function automatic int bus_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int bus_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : slave_port_pkg
`default_nettype wire

// File: rtl/slave_port_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg
//  Description : LSB-first shift register. Serial data enters at the MSB and
//                moves toward bit 0, so after WIDTH shifts the first bit
//                received sits in bit 0. Bit 0 is also the serial output, so
//                a parallel-loaded word leaves LSB first. Load wins over
//                shift when both are requested.
//  Ports       : clk          - clock, rising edge
//                rstn         - synchronous active-low reset (clears contents)
//                shift_en_i   - shift one position toward bit 0
//                load_en_i    - parallel load from load_data_i
//                sin_i        - serial input (enters at MSB)
//                load_data_i  - parallel load value
//                q_o          - parallel contents
//                sout_o       - serial output (bit 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en_i,
  input  logic             load_en_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (WIDTH > 1) begin : g_wide
      assign w_shifted = {sin_i, data_q[WIDTH-1:1]};
    end else begin : g_narrow
      assign w_shifted = sin_i;
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (load_en_i) begin
      data_d = load_data_i;
    end else if (shift_en_i) begin
      data_d = w_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o    = data_q;
  assign sout_o = data_q[0];

endmodule : shift_reg
`default_nettype wire

// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : slave_port
//  Description : Slave end of a one-bit serial bus. Receives an LSB-first
//                address (and, for writes, a data word), performs one access
//                on a simple parallel local-memory interface, and for reads
//                serialises the returned word back to the bus LSB first.
//  Ports       : clk        - single clock, rising edge
//                rstn       - synchronous active-low reset
//                swdata     - serial address / write data from bus
//                smode      - 0 read, 1 write; taken with the first bit
//                mvalid     - swdata valid this cycle
//                srdata     - serial read data to bus
//                svalid     - srdata valid this cycle
//                sready     - port idle, can accept a new transaction
//                mem_addr   - parallel address to local memory
//                mem_wdata  - parallel write data
//                mem_wen    - one-cycle write strobe
//                mem_ren    - one-cycle read request strobe
//                mem_rdata  - read data from memory
//                mem_rvalid - mem_rdata valid
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int c_MAX_W = bus_max(ADDR_WIDTH, DATA_WIDTH);
  localparam int c_CNT_W = bus_cnt_width(c_MAX_W);

  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_MAX_W - 1);
  // Address bit 0 is taken in IDLE, so ADDR only counts the remaining
  // ADDR_WIDTH-1 bits. With a one-bit address ADDR is never entered.
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST =
    c_CNT_W'((ADDR_WIDTH > 1) ? (ADDR_WIDTH - 2) : 0);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

  bus_state_e         state_q;
  bus_state_e         state_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;
  logic               write_q;
  logic               write_d;
  logic               sready_q;
  logic               svalid_q;
  logic               mem_wen_q;
  logic               mem_ren_q;

  logic               w_bit_cnt;
  logic               w_addr_shift;
  logic               w_data_shift;
  logic               w_tx_load;
  logic               w_tx_shift;
  logic               w_tx_sout;

  logic                  w_addr_sout_unused;
  logic                  w_data_sout_unused;
  logic [DATA_WIDTH-1:0] w_tx_q_unused;

  // --------------------------------------------------------------------------
  // Next-state decode. mvalid only matters in IDLE/ADDR/WDATA and mem_rvalid
  // only in RWAIT; every other state simply ignores them.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    w_bit_cnt    = 1'b0;
    w_addr_shift = 1'b0;
    w_data_shift = 1'b0;
    w_tx_load    = 1'b0;
    w_tx_shift   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mvalid) begin
          w_addr_shift = 1'b1;
          write_d      = smode;
          if (ADDR_WIDTH > 1) begin
            state_d = ST_ADDR;
          end else if (smode) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RREQ;
          end
        end
      end

      ST_ADDR: begin
        if (mvalid) begin
          w_addr_shift = 1'b1;
          w_bit_cnt    = 1'b1;
          if (cnt_q == c_ADDR_LAST) begin
            if (write_q) begin
              state_d = ST_WDATA;
            end else begin
              state_d = ST_RREQ;
            end
          end
        end
      end

      ST_WDATA: begin
        if (mvalid) begin
          w_data_shift = 1'b1;
          w_bit_cnt    = 1'b1;
          if (cnt_q == c_DATA_LAST) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_RREQ: begin
        state_d = ST_RWAIT;
      end

      ST_RWAIT: begin
        if (mem_rvalid) begin
          w_tx_load = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        w_tx_shift = 1'b1;
        w_bit_cnt  = 1'b1;
        if (cnt_q == c_DATA_LAST) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One counter serves address, data and transmit phases; it restarts at
  // zero on every state change so each phase counts from its first bit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (w_bit_cnt) begin
      if (cnt_q == c_CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register. Outputs are decoded from the next state so each one is
  // a flop that is valid for exactly the cycles spent in its state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      sready_q  <= 1'b1;
      svalid_q  <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      sready_q  <= (state_d == ST_IDLE);
      svalid_q  <= (state_d == ST_SEND);
      mem_wen_q <= (state_d == ST_WRITE);
      mem_ren_q <= (state_d == ST_RREQ);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath. The receive registers drive the memory bus directly; they only
  // move while their phase is shifting, so address and data are stable for
  // the whole access.
  // --------------------------------------------------------------------------
  shift_reg #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_sr (
    .clk         (clk),
    .rstn        (rstn),
    .shift_en_i  (w_addr_shift),
    .load_en_i   (1'b0),
    .sin_i       (swdata),
    .load_data_i ('0),
    .q_o         (mem_addr),
    .sout_o      (w_addr_sout_unused)
  );

  shift_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_wdata_sr (
    .clk         (clk),
    .rstn        (rstn),
    .shift_en_i  (w_data_shift),
    .load_en_i   (1'b0),
    .sin_i       (swdata),
    .load_data_i ('0),
    .q_o         (mem_wdata),
    .sout_o      (w_data_sout_unused)
  );

  // Transmit: loaded on the RWAIT->SEND edge so bit 0 is on srdata in the
  // first SEND cycle; zeros shift in behind the word.
  shift_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_tx_sr (
    .clk         (clk),
    .rstn        (rstn),
    .shift_en_i  (w_tx_shift),
    .load_en_i   (w_tx_load),
    .sin_i       (1'b0),
    .load_data_i (mem_rdata),
    .q_o         (w_tx_q_unused),
    .sout_o      (w_tx_sout)
  );

  assign srdata    = svalid_q & w_tx_sout;
  assign svalid    = svalid_q;
  assign sready    = sready_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;

endmodule : slave_port
`default_nettype wire

// File: tb/tb_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_port
//  Description : Self-checking bench for slave_port. Drives serial
//                transactions, models local memory and checks strobes,
//                latencies and serialised read data against bus-level rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_port;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int LIMIT = 200;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          swdata = 1'b0;
  logic          smode = 1'b0;
  logic          mvalid = 1'b0;
  logic          srdata;
  logic          svalid;
  logic          sready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  slave_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .swdata     (swdata),
    .smode      (smode),
    .mvalid     (mvalid),
    .srdata     (srdata),
    .svalid     (svalid),
    .sready     (sready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory contents.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];

  // ---------------- bus monitor ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  wr_t  wr_q[$];
  wr_t  mon_e;
  logic rd_bits[$];
  int   ren_cnt    = 0;
  int   ren_cyc    = -1;
  int   sv_first   = -1;
  int   sv_last    = -1;
  int   idle_noise = 0;

  always @(negedge clk) begin
    if (mem_wen) begin
      mon_e.a = mem_addr;
      mon_e.d = mem_wdata;
      mon_e.c = cyc;
      wr_q.push_back(mon_e);
    end
    if (mem_ren) begin
      ren_cnt++;
      ren_cyc = cyc;
    end
    if (svalid) begin
      rd_bits.push_back(srdata);
      if (sv_first < 0) sv_first = cyc;
      sv_last = cyc;
    end else if (srdata !== 1'b0) begin
      idle_noise++;
    end
  end

  // ---------------- memory responder ----------------
  int            rd_delay = 3;
  int            rd_wait  = 0;
  bit            noise_en = 1'b0;
  logic [AW-1:0] rd_addr  = '0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    if (mem_ren) begin
      rd_wait = rd_delay;
      rd_addr = mem_addr;
    end else if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_model[rd_addr];
      end
    end else if (noise_en) begin
      // Stray valids while no read is outstanding must be ignored.
      mem_rvalid = 1'($urandom);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_bits.delete();
    ren_cnt  = 0;
    ren_cyc  = -1;
    sv_first = -1;
    sv_last  = -1;
  endtask

  // Sends nbits serial bits: address LSB first, then data LSB first.
  // gapmode 0: contiguous, 1: random idle gaps, 2: two idle cycles after
  // the 4th and the 15th bit.
  task automatic drive_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int gapmode, input int nbits,
                           output int first_c, output int last_c);
    first_c = -1;
    last_c  = -1;
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = 0;
      if (gapmode == 1 && i > 0) g = $urandom_range(0, 2);
      if (gapmode == 2 && (i == 4 || i == 15)) g = 2;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        mvalid = 1'b0;
        swdata = 1'($urandom);
        smode  = 1'($urandom);
      end
      @(negedge clk);
      if (i == 0) chk("sready_idle", 32'(sready), 32'd1);
      if (i == 1) chk("sready_busy", 32'(sready), 32'd0);
      mvalid = 1'b1;
      swdata = (i < AW) ? a[i] : d[i-AW];
      smode  = (i == 0) ? wr : 1'($urandom);
      if (i == 0) first_c = cyc;
      last_c = cyc;
    end
    @(negedge clk);
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  // Waits for sready; optionally wiggles mvalid/swdata while busy.
  task automatic wait_idle(input bit toggle, output int t);
    t = 0;
    while (t < LIMIT) begin
      @(negedge clk);
      if (sready === 1'b1) break;
      t++;
      if (toggle) begin
        mvalid = 1'($urandom);
        swdata = 1'($urandom);
        smode  = 1'($urandom);
      end
    end
    mvalid = 1'b0;
  endtask

  int span;

  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gapmode);
    int f, l, t;
    clear_mon();
    mem_model[a] = d;
    drive_txn(1'b1, a, d, gapmode, AW + DW, f, l);
    span = l - f;
    wait_idle(1'b0, t);
    chk("wr_timeout", 32'(t < LIMIT), 32'd1);
    chk("wr_sready_rise", 32'(cyc), 32'(l + 2));
    chk("wr_strobes", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      chk("wr_addr", 32'(wr_q[0].a), 32'(a));
      chk("wr_data", 32'(wr_q[0].d), 32'(d));
      chk("wr_latency", 32'(wr_q[0].c), 32'(l + 1));
    end
    chk("wr_no_ren", 32'(ren_cnt), 32'd0);
    chk("wr_no_svalid", 32'(rd_bits.size()), 32'd0);
  endtask

  task automatic run_read(input logic [AW-1:0] a, input int delay, input bit toggle,
                          input int gapmode);
    int f, l, t;
    logic [DW-1:0] got;
    clear_mon();
    rd_delay = delay;
    drive_txn(1'b0, a, '0, gapmode, AW, f, l);
    wait_idle(toggle, t);
    chk("rd_timeout", 32'(t < LIMIT), 32'd1);
    chk("rd_ren_count", 32'(ren_cnt), 32'd1);
    chk("rd_ren_cyc", 32'(ren_cyc), 32'(l + 1));
    chk("rd_nbits", 32'(rd_bits.size()), 32'(DW));
    got = '0;
    for (int i = 0; i < rd_bits.size() && i < DW; i++) got[i] = rd_bits[i];
    chk("rd_data", 32'(got), 32'(mem_model[a]));
    chk("rd_first_bit_cyc", 32'(sv_first), 32'(l + 2 + delay));
    chk("rd_svalid_run", 32'(sv_last - sv_first + 1), 32'(DW));
    chk("rd_no_write", 32'(wr_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("rd_stays_idle", 32'(sready), 32'd1);
    chk("rd_no_restart", 32'(ren_cnt), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int exp36 [DW] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int f0, l0, t0;
  int span_contig;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = DW'($urandom);

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_srdata",    32'(srdata),    32'd0);
    chk("rst_svalid",    32'(svalid),    32'd0);
    chk("rst_sready",    32'(sready),    32'd1);
    chk("rst_mem_wen",   32'(mem_wen),   32'd0);
    chk("rst_mem_ren",   32'(mem_ren),   32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rstn = 1'b1;

    // Contiguous write.
    run_write(12'h5A3, 8'hC7, 0);
    span_contig = span;

    // Read with 3-cycle memory latency, mvalid wiggling while busy.
    mem_model[12'h0FF] = 8'h3C;
    run_read(12'h0FF, 3, 1'b1, 0);
    for (int i = 0; i < DW; i++) begin
      chk("rd36_bit", (rd_bits.size() > i) ? 32'(rd_bits[i]) : 32'hFFFF_FFFF, 32'(exp36[i]));
    end

    // Write with two 2-cycle pauses: same result, four cycles later.
    run_write(12'h001, 8'hA5, 2);
    chk("gap_stretch", 32'(span - span_contig), 32'd4);

    // Reset after seven address bits aborts the transaction.
    clear_mon();
    drive_txn(1'b1, 12'h6B5, 8'h00, 0, 7, f0, l0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_sready",   32'(sready),   32'd1);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_wen", 32'(wr_q.size()), 32'd0);
    chk("abort_no_ren", 32'(ren_cnt),     32'd0);
    run_read(12'h7FF, 2, 1'b0, 0);

    // Randomised traffic with gaps, varying latency and stray valids.
    noise_en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      ra = AW'($urandom);
      rd = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        run_write(ra, rd, 1);
      end else begin
        run_read(ra, $urandom_range(1, 4), 1'b1, 1);
      end
    end
    noise_en = 1'b0;

    // Read back a location written just before, through the memory model.
    run_write(12'h3E9, 8'h5D, 1);
    run_read(12'h3E9, 1, 1'b1, 1);

    wait_idle(1'b0, t0);
    chk("srdata_outside_send", 32'(idle_noise), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_slave_port
`default_nettype wire
